// File: rtl/spi_frame_ctrl.sv
// Frame sequencer for the FFT accelerator: gathers SPI bytes into samples, kicks the FFT,
// then streams the complex results back out through the SPI transmitter.
module spi_frame_ctrl #(
    parameter int N         = 256,
    parameter int BIT_WIDTH = 16,
    parameter int SPI_WIDTH = 8,
    parameter int ADDR_W    = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   rx_wd,
    input  logic [SPI_WIDTH-1:0]   rx_byte,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_waddr,
    output logic [BIT_WIDTH-1:0]   mem_wdata,
    output logic                   fft_start,
    input  logic                   fft_done,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [2*BIT_WIDTH-1:0] rd_data,
    output logic [2*BIT_WIDTH-1:0] tx_word,
    output logic                   play_back,
    input  logic                   tx_req,
    output logic                   busy,
    output logic                   frame_err
);
    typedef enum logic [1:0] {IDLE, LOAD, FFT, PLAY} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t                state, state_next;
    logic [2:0]            cs_sync, rx_sync, tx_sync;
    logic                  cs_fall, cs_rise, rx_edge, tx_edge;
    logic [ADDR_W-1:0]     count;
    logic                  phase, last_wr, start_load;
    logic [1:0]            tx_pipe;
    logic [SPI_WIDTH-1:0]  hi_byte;
    logic                  write_fire, abort, play_done;

    // Bits [1:0] are the synchronizer pair, bit [2] holds the previous value for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync <= '0;
            rx_sync <= '0;
            tx_sync <= '0;
        end else begin
            cs_sync <= {cs_sync[1:0], cs};
            rx_sync <= {rx_sync[1:0], rx_wd};
            tx_sync <= {tx_sync[1:0], tx_req};
        end
    end

    assign rx_edge = rx_sync[1] & ~rx_sync[2];
    assign tx_edge = tx_sync[1] & ~tx_sync[2];
    assign cs_fall = ~cs_sync[1] & cs_sync[2];
    assign cs_rise = cs_sync[1] & ~cs_sync[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A cs_rise coinciding with the edge that completes the frame is not an abort.
    always_comb begin
        state_next = state;
        write_fire = 1'b0;
        abort      = 1'b0;
        play_done  = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_next = LOAD;
            LOAD: begin
                write_fire = rx_edge && phase && !last_wr;
                abort      = cs_rise && !last_wr && !(write_fire && count == LAST);
                if (abort)        state_next = IDLE;
                else if (last_wr) state_next = FFT;
            end
            FFT:  if (fft_done) state_next = PLAY;
            PLAY: begin
                play_done = tx_edge && rd_addr == LAST;
                if (play_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            fft_start  <= 1'b0;
            rd_addr    <= '0;
            tx_word    <= '0;
            play_back  <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            count      <= '0;
            phase      <= 1'b0;
            last_wr    <= 1'b0;
            start_load <= 1'b0;
            tx_pipe    <= '0;
            hi_byte    <= '0;
        end else begin
            mem_we    <= 1'b0;
            fft_start <= 1'b0;
            frame_err <= 1'b0;
            busy      <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        count   <= '0;
                        phase   <= 1'b0;
                        last_wr <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        frame_err <= 1'b1;
                        phase     <= 1'b0;
                    end else if (last_wr) begin
                        fft_start <= 1'b1;
                        last_wr   <= 1'b0;
                    end else if (rx_edge) begin
                        if (!phase) begin
                            hi_byte <= rx_byte;
                            phase   <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_waddr <= count;
                            mem_wdata <= BIT_WIDTH'({hi_byte, rx_byte});
                            count     <= count + 1'b1;
                            phase     <= 1'b0;
                            last_wr   <= (count == LAST);
                        end
                    end
                end
                FFT: begin
                    if (fft_done) begin
                        rd_addr    <= '0;
                        start_load <= 1'b1;
                        tx_pipe    <= '0;
                    end
                end
                PLAY: begin
                    // rd_data lags rd_addr by one cycle, so the capture trails tx_edge by two.
                    tx_pipe <= {tx_pipe[0], tx_edge};
                    if (start_load) begin
                        tx_word    <= rd_data;
                        play_back  <= 1'b1;
                        start_load <= 1'b0;
                    end else if (tx_pipe[1]) begin
                        tx_word <= rd_data;
                    end
                    if (play_done) begin
                        play_back <= 1'b0;
                        tx_word   <= '0;
                        rd_addr   <= '0;
                        tx_pipe   <= '0;
                    end else if (tx_edge) begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Randomized self-checking bench for spi_frame_ctrl at N=4 with sclk modelled as clk/4.
module tb_spi_frame_ctrl;
    localparam int N  = 4;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b1;
    logic        rx_wd = 1'b0;
    logic        tx_req = 1'b0;
    logic        fft_done = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        mem_we, fft_start, play_back, busy, frame_err;
    logic [AW-1:0] mem_waddr, rd_addr;
    logic [15:0] mem_wdata;
    logic [31:0] rd_data, tx_word;
    logic [31:0] res_mem [N];
    logic [63:0] outs;

    int total = 0;
    int bad = 0;

    // Observations of the write side, collected by the monitor
    int          cyc = 0;
    logic [AW-1:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          last_wr_cyc, start_cnt, start_cyc, err_cnt, we_long;
    logic        prev_we = 1'b0;

    spi_frame_ctrl #(.N(N), .BIT_WIDTH(16), .SPI_WIDTH(8), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rx_wd(rx_wd), .rx_byte(rx_byte),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .fft_start(fft_start), .fft_done(fft_done), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_word(tx_word), .play_back(play_back), .tx_req(tx_req), .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= res_mem[rd_addr];

    assign outs = {7'd0, mem_we, mem_waddr, mem_wdata, fft_start, rd_addr, tx_word,
                   play_back, busy, frame_err};

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_waddr);
                wr_data_q.push_back(mem_wdata);
                last_wr_cyc = cyc;
                if (prev_we) we_long = we_long + 1;
            end
            if (fft_start) begin
                start_cnt = start_cnt + 1;
                start_cyc = cyc;
            end
            if (frame_err) err_cnt = err_cnt + 1;
        end
        prev_we = mem_we;
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_monitor();
        wr_addr_q.delete();
        wr_data_q.delete();
        last_wr_cyc = -10;
        start_cnt   = 0;
        start_cyc   = -20;
        err_cnt     = 0;
        we_long     = 0;
    endtask

    // One byte every 8 sclk; the bus is held for 7 sclk after rx_wd rises, then scrambled.
    task automatic send_byte(input logic [7:0] b, input bit with_cs_rise);
        rx_byte = b;
        rx_wd   = 1'b1;
        if (with_cs_rise) cs = 1'b1;
        wait_clk(8);
        rx_wd = 1'b0;
        wait_clk(20);
        rx_byte = 8'($urandom);
        wait_clk(4);
    endtask

    // Sends k bytes of frame b; a short frame is ended by raising cs and must abort.
    task automatic load_frame(input logic [7:0] b [8], input int k, input bit cs_with_last);
        int nw;
        clear_monitor();
        cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < k; i++) send_byte(b[i], cs_with_last && (i == k - 1));
        if (k < 2 * N) begin
            cs = 1'b1;
            wait_clk(12);
        end else begin
            wait_clk(2);
        end
        nw = k / 2;
        check_output("write_count", 64'(wr_addr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            check_output($sformatf("waddr%0d", i), 64'(wr_addr_q[i]), 64'(i));
            check_output($sformatf("wdata%0d", i), 64'(wr_data_q[i]), 64'({b[2*i], b[2*i+1]}));
        end
        check_output("we_single_cycle", 64'(we_long), 64'd0);
        if (k < 2 * N) begin
            check_output("abort_err", 64'(err_cnt), 64'd1);
            check_output("abort_no_start", 64'(start_cnt), 64'd0);
            check_output("abort_busy", 64'(busy), 64'd0);
        end else begin
            check_output("start_count", 64'(start_cnt), 64'd1);
            check_output("start_timing", 64'(start_cyc - last_wr_cyc), 64'd1);
            check_output("full_no_err", 64'(err_cnt), 64'd0);
            check_output("fft_busy", 64'(busy), 64'd1);
        end
    endtask

    // FFT gating, then playback of r with cs toggling around each word.
    task automatic play_frame(input logic [31:0] r [N]);
        for (int i = 0; i < N; i++) res_mem[i] = r[i];
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        check_output("fft_gating_writes", 64'(wr_addr_q.size()), 64'(N));
        check_output("fft_gating_start", 64'(start_cnt), 64'd1);
        cs = 1'b1;
        wait_clk(8);
        check_output("fft_wait_busy", 64'(busy), 64'd1);
        fft_done = 1'b1;
        wait_clk(1);
        fft_done = 1'b0;
        wait_clk(1);
        check_output("play_start", 64'(play_back), 64'd1);
        check_output("tx_word0", 64'(tx_word), 64'(r[0]));
        for (int i = 0; i < N; i++) begin
            cs = 1'b0;
            wait_clk(6);
            tx_req = 1'b1;
            wait_clk(16);
            tx_req = 1'b0;
            wait_clk(10);
            cs = 1'b1;
            wait_clk(6);
            if (i < N - 1) begin
                check_output($sformatf("tx_word%0d", i + 1), 64'(tx_word), 64'(r[i + 1]));
                check_output($sformatf("play_on%0d", i + 1), 64'(play_back), 64'd1);
                check_output($sformatf("rd_addr%0d", i + 1), 64'(rd_addr), 64'(i + 1));
            end else begin
                check_output("play_end", 64'(play_back), 64'd0);
                check_output("tx_word_cleared", 64'(tx_word), 64'd0);
                check_output("end_busy", 64'(busy), 64'd0);
                check_output("rd_addr_wrapped", 64'(rd_addr), 64'd0);
            end
        end
    endtask

    initial begin
        logic [7:0]  fr [8];
        logic [31:0] rr [N];
        int k;
        for (int i = 0; i < N; i++) res_mem[i] = 32'd0;
        clear_monitor();

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            cs       = 1'($urandom);
            rx_wd    = 1'($urandom);
            tx_req   = 1'($urandom);
            fft_done = 1'($urandom);
            rx_byte  = 8'($urandom);
            wait_clk(1);
            check_output("reset_outputs", outs, 64'd0);
        end
        cs = 1'b1; rx_wd = 1'b0; tx_req = 1'b0; fft_done = 1'b0;
        wait_clk(2);
        reset = 1'b1;
        send_byte(8'h55, 1'b0);
        check_output("idle_after_reset", outs, 64'd0);

        // Directed frame and playback
        fr = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load_frame(fr, 8, 1'b0);
        rr = '{32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
        play_frame(rr);

        // Directed abort after three bytes
        fr = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_frame(fr, 3, 1'b0);

        // cs rising together with the final byte must still complete the frame
        for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
        load_frame(fr, 8, 1'b1);
        for (int i = 0; i < N; i++) rr[i] = $urandom;
        play_frame(rr);

        // Random frames, some aborted at random points
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
            k = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(0, 7));
            load_frame(fr, k, 1'b0);
            if (k == 8) begin
                for (int i = 0; i < N; i++) rr[i] = $urandom;
                play_frame(rr);
            end
        end

        // Asynchronous reset in the middle of playback
        for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
        load_frame(fr, 8, 1'b0);
        cs = 1'b1;
        wait_clk(8);
        for (int i = 0; i < N; i++) res_mem[i] = $urandom | 32'h1;
        fft_done = 1'b1;
        wait_clk(1);
        fft_done = 1'b0;
        wait_clk(4);
        check_output("mid_play_active", 64'(play_back), 64'd1);
        reset = 1'b0;
        #1;
        check_output("mid_play_reset", outs, 64'd0);
        wait_clk(3);
        reset = 1'b1;
        wait_clk(10);
        check_output("after_mid_reset", outs, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
- Sequences the SPI receive/transmit path around the FFT core, in the system clock domain.
- Synchronizes SPI-domain strobes and assembles received byte pairs into 16-bit samples. Writes N samples into the FFT input buffer, pulses the FFT start, and waits for done.
- After the FFT, streams the N complex results back to the SPI transmitter one 32-bit word at a time.

Parameters:
- N, 256, frame length in samples (power of 2, ≥4)
- BIT_WIDTH, 16, sample / result-component width
- SPI_WIDTH, 8, SPI byte width
- ADDR_W, $clog2(N), buffer address width

Ports:
- clk  in  1  system clock (≥4× sclk)
- reset  in  1  asynchronous, active-low reset
- cs  in  1  SPI chip select, raw from pad, active low
- rx_wd  in  1  SPI byte-received flag, sclk domain
- rx_byte  in  SPI_WIDTH  received byte, sclk domain; stable ≥7 sclk after rx_wd rises
- mem_we  out  1  input-buffer write strobe
- mem_waddr  out  ADDR_W  input-buffer write address
- mem_wdata  out  BIT_WIDTH  sample, {first byte, second byte}
- fft_start  out  1  one-cycle FFT start pulse
- fft_done  in  1  one-cycle FFT completion pulse
- rd_addr  out  ADDR_W  result-buffer read address (1-cycle read latency)
- rd_data  in  2*BIT_WIDTH  result {real, imag}
- tx_word  out  2*BIT_WIDTH  word presented to SPI transmitter
- play_back  out  1  transmit-enable level to SPI
- tx_req  in  1  SPI word-shifted-out flag, sclk domain
- busy  out  1  high in any state except IDLE
- frame_err  out  1  one-cycle pulse on aborted load

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; counters, hi-byte register and sync flops cleared.
- Synchronization:
  - cs, rx_wd and tx_req each pass through 2 flops plus 1 edge-detect flop.
  - rx_edge, tx_edge = synced rising edges; cs_fall / cs_rise = synced edges of cs.
  - rx_byte is sampled in the same cycle rx_edge is seen; no sync flop on the bus.
- States: IDLE, LOAD, FFT, PLAY.
- IDLE:
  - cs_fall → LOAD; sample count=0, byte phase=0.
  - rx_edge is ignored.
- LOAD:
  - rx_edge with phase 0: hi byte ← rx_byte; phase ← 1.
  - rx_edge with phase 1: next cycle, mem_we=1 for exactly one cycle, mem_waddr=count, mem_wdata={hi, rx_byte}; count++ ; phase ← 0.
  - After the write with count==N-1: fft_start=1 the following cycle; state → FFT.
  - cs_rise before N samples written: state → IDLE, frame_err pulse, partial hi byte discarded, no further writes.
  - cs_rise in the same cycle as the final rx_edge: the final write and fft_start still occur; no error.
- FFT:
  - rx_edge, tx_edge and cs edges are ignored.
  - fft_done → PLAY with rd_addr=0.
- PLAY:
  - One cycle after entry, tx_word ← rd_data and play_back=1.
  - Each tx_edge: words sent++, rd_addr++; tx_word updated with the new rd_data 2 cycles after tx_edge.
  - On the N-th tx_edge: play_back=0, tx_word=0, state → IDLE.
  - cs toggling does not abort PLAY; the MCU may read across multiple transactions.
- rd_addr wraps only via return to IDLE; it never exceeds N-1.
- busy = (state != IDLE), registered.
- Reset asserted mid-LOAD or mid-PLAY: immediate return to reset values; a buffer write in flight is suppressed.

Test Plan (N=4):
- Reset: hold reset=0 with random inputs → all outputs 0, state IDLE. Release reset → stays IDLE until a cs falling edge.
- Load: cs low, send bytes 12 34 56 78 9A BC DE F0.
  - Writes: addr0=1234, addr1=5678, addr2=9ABC, addr3=DEF0, each mem_we exactly 1 cycle.
  - fft_start pulses once, 1 cycle after the last write; busy=1.
- Abort: cs low, send 3 bytes AA BB CC, cs high.
  - Exactly one write: addr0=AABB.
  - frame_err pulses once; state IDLE.
  - Next frame starts at addr0.
- FFT gating: in FFT state send 2 extra bytes → no mem_we. fft_done pulse → play_back=1 and tx_word=rd_data[addr0] within 2 cycles.
- Playback: result mem {00010002, 00030004, 00050006, 00070008}. 4 tx_req pulses with cs toggling between them → tx_word steps through the values in order. play_back=0 after the 4th; busy=0.
- Timing margin: sclk=clk/4 → no byte lost, with rx_byte sampled correctly on every rx_edge.
